// File: rtl/counter_pipeline_gen.sv
// Range counter feeding a DEPTH-stage delay line with per-stage valid bits,
// three combinational taps and IDLE/RUN/DRAIN sequencing for the MD5 datapath.
module counter_pipeline_gen #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 48,
    parameter int unsigned TAP0      = 19,
    parameter int unsigned TAP1      = 41,
    parameter int unsigned TAP2      = 48,
    parameter int unsigned BYTE_SWAP = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             abort,
    input  logic             advance,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] limit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] counter_tap0,
    output logic [WIDTH-1:0] counter_tap1,
    output logic [WIDTH-1:0] counter_tap2,
    output logic             valid_tap0,
    output logic             valid_tap1,
    output logic             valid_tap2
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Only the last stage holding a valid value: the range is about to exit.
    localparam logic [DEPTH-1:0] LAST_ONLY = (DEPTH)'(1) << (DEPTH - 1);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] cnt_sw;
    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] vld;

    generate
        if (TAP0 < 1 || TAP0 > DEPTH || TAP1 < 1 || TAP1 > DEPTH ||
            TAP2 < 1 || TAP2 > DEPTH) begin : g_bad_tap
            $fatal(1, "counter_pipeline_gen: TAPn must lie in 1..DEPTH");
        end
        if (BYTE_SWAP != 0 && (WIDTH % 8) != 0) begin : g_bad_width
            $fatal(1, "counter_pipeline_gen: WIDTH must be a multiple of 8 when BYTE_SWAP=1");
        end

        if (BYTE_SWAP != 0) begin : g_swap
            always_comb begin
                cnt_sw = '0;
                for (int unsigned i = 0; i < WIDTH / 8; i++) begin
                    cnt_sw[8*(WIDTH/8-1-i) +: 8] = cnt[8*i +: 8];
                end
            end
        end else begin : g_noswap
            assign cnt_sw = cnt;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            lim   <= '0;
            vld   <= '0;
            done  <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else if (abort) begin
            state <= IDLE;
            vld   <= '0;
            done  <= 1'b0;
        end else begin
            // A start is accepted even on a stalled edge.
            if (state == IDLE && start) begin
                cnt   <= base;
                lim   <= limit;
                state <= RUN;
            end
            if (advance) begin
                done <= 1'b0;
                vld  <= (vld << 1) | (DEPTH)'(state == RUN);
                if (state != IDLE) begin
                    stage[0] <= cnt_sw;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        stage[k] <= stage[k-1];
                    end
                end
                case (state)
                    RUN: begin
                        if (cnt == lim) begin
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + (WIDTH)'(1);
                        end
                    end
                    DRAIN: begin
                        if (vld == LAST_ONLY) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy         = (state != IDLE);
    assign counter_tap0 = stage[TAP0-1];
    assign counter_tap1 = stage[TAP1-1];
    assign counter_tap2 = stage[TAP2-1];
    assign valid_tap0   = vld[TAP0-1];
    assign valid_tap1   = vld[TAP1-1];
    assign valid_tap2   = vld[TAP2-1];

endmodule

// File: tb/tb_counter_pipeline_gen.sv
// Directed self-checking bench for counter_pipeline_gen: default build plus a
// small 16-bit, 8-stage, no-swap build.
module tb_counter_pipeline_gen;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start, abort, advance;
    logic [31:0] base, limit;
    logic        busy, done;
    logic [31:0] counter_tap0, counter_tap1, counter_tap2;
    logic        valid_tap0, valid_tap1, valid_tap2;

    logic        v_start, v_abort, v_adv;
    logic [15:0] v_base, v_limit;
    logic        v_busy, v_done;
    logic [15:0] v_tap0, v_tap1, v_tap2;
    logic        v_valid0, v_valid1, v_valid2;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_v [0:15];

    always #5 CLK = ~CLK;

    counter_pipeline_gen dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .advance(advance),
        .base(base), .limit(limit), .busy(busy), .done(done),
        .counter_tap0(counter_tap0), .counter_tap1(counter_tap1), .counter_tap2(counter_tap2),
        .valid_tap0(valid_tap0), .valid_tap1(valid_tap1), .valid_tap2(valid_tap2)
    );

    counter_pipeline_gen #(
        .WIDTH(16), .DEPTH(8), .TAP0(1), .TAP1(4), .TAP2(8), .BYTE_SWAP(0)
    ) dut_small (
        .CLK(CLK), .RST_N(RST_N), .start(v_start), .abort(v_abort), .advance(v_adv),
        .base(v_base), .limit(v_limit), .busy(v_busy), .done(v_done),
        .counter_tap0(v_tap0), .counter_tap1(v_tap1), .counter_tap2(v_tap2),
        .valid_tap0(v_valid0), .valid_tap1(v_valid1), .valid_tap2(v_valid2)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tap_chk(input string tag, input int idx, input logic v,
                           input logic [31:0] d, input int nvals);
        logic ev;
        ev = (idx >= 0) && (idx < nvals);
        chk1({tag, "_valid"}, v, ev);
        if (ev) chk32({tag, "_data"}, d, exp_v[idx]);
    endtask

    task automatic start_range(input logic [31:0] b, input logic [31:0] l);
        base    = b;
        limit   = l;
        start   = 1'b1;
        advance = 1'b1;
        step();
        start   = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
    endtask

    // Value i is issued on advancing edge i+1 and sits at stage T after edge i+T.
    task automatic run_range(input int nvals, input bit rnd);
        int   a;
        int   last;
        logic adv;
        a    = 0;
        last = nvals + 48;
        for (int it = 0; it < 2000 && a < last; it++) begin
            adv     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            advance = adv;
            step();
            if (adv) a++;
            tap_chk("tap0", a - 19, valid_tap0, counter_tap0, nvals);
            tap_chk("tap1", a - 41, valid_tap1, counter_tap1, nvals);
            tap_chk("tap2", a - 48, valid_tap2, counter_tap2, nvals);
            chk1("busy", busy, a < last);
            chk1("done", done, a == last);
        end
        chk32("drain_bound", 32'(a), 32'(last));
        advance = 1'b1;
        step();
        chk1("done_fall", done, 1'b0);
        chk1("busy_idle", busy, 1'b0);
    endtask

    initial begin
        RST_N = 1'b0;
        start = 1'b0; abort = 1'b0; advance = 1'b0; base = '0; limit = '0;
        v_start = 1'b0; v_abort = 1'b0; v_adv = 1'b0; v_base = '0; v_limit = '0;

        #7;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk32("rst_tap0", counter_tap0, 32'h0);
        chk32("rst_tap2", counter_tap2, 32'h0);
        chk1("rst_valid0", valid_tap0, 1'b0);
        #5 RST_N = 1'b1;

        // Basic range 0x10..0x12, byte-swapped.
        exp_v[0] = 32'h1000_0000;
        exp_v[1] = 32'h1100_0000;
        exp_v[2] = 32'h1200_0000;
        start_range(32'h0000_0010, 32'h0000_0012);
        run_range(3, 1'b0);

        // Wrap through all-ones.
        exp_v[0] = 32'hFEFF_FFFF;
        exp_v[1] = 32'hFFFF_FFFF;
        exp_v[2] = 32'h0000_0000;
        exp_v[3] = 32'h0100_0000;
        start_range(32'hFFFF_FFFE, 32'h0000_0001);
        run_range(4, 1'b0);

        // Random stalls over 0x20..0x29.
        for (int i = 0; i < 10; i++) exp_v[i] = {8'h20 + 8'(i), 24'h0};
        start_range(32'h0000_0020, 32'h0000_0029);
        run_range(10, 1'b1);

        // Abort with a simultaneous start after 5 issues.
        start_range(32'h0000_0100, 32'h0000_01FF);
        for (int i = 0; i < 5; i++) step();
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            chk32("abort_flush", {29'h0, valid_tap0, valid_tap1, valid_tap2}, 32'h0);
            chk1("abort_nodone", done, 1'b0);
        end
        exp_v[0] = 32'h3000_0000;
        start_range(32'h0000_0030, 32'h0000_0030);
        run_range(1, 1'b0);

        // Asynchronous reset while draining.
        start_range(32'h0000_0040, 32'h0000_0041);
        for (int i = 0; i < 42; i++) step();
        chk1("drain_busy", busy, 1'b1);
        chk1("drain_valid1", valid_tap1, 1'b1);
        chk32("drain_tap1", counter_tap1, 32'h4100_0000);
        #2 RST_N = 1'b0;
        #1;
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_done", done, 1'b0);
        chk1("arst_valid1", valid_tap1, 1'b0);
        chk32("arst_tap1", counter_tap1, 32'h0);
        #3 RST_N = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk32("arst_quiet", {28'h0, busy, done, valid_tap1, valid_tap2}, 32'h0);
        end

        // 16-bit, 8-stage, no-swap build.
        v_base  = 16'hABCD;
        v_limit = 16'hABCD;
        v_start = 1'b1;
        v_adv   = 1'b1;
        step();
        v_start = 1'b0;
        chk1("v_busy_start", v_busy, 1'b1);
        for (int n = 1; n <= 10; n++) begin
            step();
            chk1("v_valid0", v_valid0, n == 1);
            chk1("v_valid1", v_valid1, n == 4);
            chk1("v_valid2", v_valid2, n == 8);
            if (n == 1) chk32("v_tap0", {16'h0, v_tap0}, 32'h0000_ABCD);
            if (n == 4) chk32("v_tap1", {16'h0, v_tap1}, 32'h0000_ABCD);
            if (n == 8) chk32("v_tap2", {16'h0, v_tap2}, 32'h0000_ABCD);
            chk1("v_done", v_done, n == 9);
        end
        chk1("v_busy_end", v_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_pipeline_gen.md
Name: counter_pipeline_gen

Overview:
- Parametrised successor to the fixed counter delay line in the MD5 brute-force datapath.
- Generates candidate counter values internally over an inclusive range [base, limit], wrapping past 2^WIDTH-1 when needed.
- Optionally byte-swaps each value into message-word order, then carries it down a DEPTH-stage delay line with per-stage valid bits.
- Exposes three tap points aligned to the MD5 rounds that consume the counter word. Adds start/abort/done control and a global stall.

Parameters:
- WIDTH, 32, counter width in bits; must be a multiple of 8 when BYTE_SWAP=1.
- DEPTH, 48, number of delay stages.
- TAP0, 19, stage index for tap 0 (1..DEPTH).
- TAP1, 41, stage index for tap 1 (1..DEPTH).
- TAP2, 48, stage index for tap 2 (1..DEPTH).
- BYTE_SWAP, 1, 1 = reverse byte order before stage 1; 0 = pass value unchanged.

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a range; sampled in IDLE only.
- abort  in  1  synchronous cancel; highest priority after reset.
- advance  in  1  pipeline enable; 0 freezes the generator, the stages and the FSM.
- base  in  WIDTH  first counter value, latched on an accepted start.
- limit  in  WIDTH  last counter value (inclusive), latched on an accepted start.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the range has fully exited stage DEPTH.
- counter_tap0/1/2  out  WIDTH each  stage[TAPn] data.
- valid_tap0/1/2  out  1 each  stage[TAPn] valid.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - FSM = IDLE.
  - All stage data and valid bits = 0; internal counter and latched limit = 0.
  - busy = 0, done = 0; all tap outputs = 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches base into cnt and limit into lim, then moves to RUN next cycle; advance is not required for this.
  - start is ignored in RUN and DRAIN.
- Advancing edge (advance=1):
  - stage[1] <= swap(cnt), valid[1] <= (state==RUN).
  - stage[k] <= stage[k-1], valid[k] <= valid[k-1] for k = 2..DEPTH.
- Issue in RUN on an advancing edge:
  - If cnt == lim, move to DRAIN and leave cnt unchanged.
  - Otherwise cnt <= cnt + 1, modulo 2^WIDTH.
- Issue count: (lim - base) mod 2^WIDTH + 1. base == limit issues exactly one value; limit < base wraps through all-ones to 0.
- Stalled edge (advance=0): no state, data, valid or counter change in any state.
- Data in the pipeline does not shift while in IDLE, even if advance=1, except for valid zeros. Stage data only needs to be meaningful where its valid bit is 1.
- DRAIN:
  - Stage 1 loads valid=0.
  - On the advancing edge where valid[DEPTH] is 1 and valid[1..DEPTH-1] are all 0, move to IDLE and assert done for the following single cycle.
- Latency: a value issued on edge E appears at stage k after edge E+k-1 advancing edges (stage 1 immediately after E).
- swap(): byte i maps to byte (WIDTH/8-1-i); identity when BYTE_SWAP=0.
- abort=1 on any edge, regardless of advance:
  - Clear all valid bits and go to IDLE.
  - No done pulse; cnt retained.
- start and abort on the same edge: abort wins and start is dropped.
- Taps are purely combinational from the stage registers; no extra latency.
- Elaboration: out-of-range TAPn or a WIDTH not a multiple of 8 with BYTE_SWAP=1 is a fatal parameter error.

Test Plan:
- Basic range: reset, base=0x00000010, limit=0x00000012, start, advance=1 held -> exactly 3 valids at tap0; stage 19 shows 0x10000000, 0x11000000, 0x12000000 on consecutive cycles, 18 edges after first issue; done pulses once, 48 edges after last issue; busy falls with done.
- Wrap: base=0xFFFFFFFE, limit=0x00000001 -> 4 values issued: FE FF FF FF, FF FF FF FF, 00000000, 01000000 (swapped); no extra or missing valid.
- Stall: random advance duty ~50% over a 10-value range -> tap sequences identical to the advance=1 run, gaps only while advance=0; cnt, state and done frozen during stalls.
- Abort mid-RUN with start on the same edge: after 5 issues -> all valid_tap* = 0 next cycle, busy=0, no done; a subsequent start is accepted normally.
- Async reset mid-DRAIN: RST_N pulsed low between clock edges -> outputs clear immediately without waiting for CLK; state IDLE; no done.
- Parameter variant: WIDTH=16, DEPTH=8, TAP0=1, TAP1=4, TAP2=8, BYTE_SWAP=0, base=limit=0xABCD -> single valid 0xABCD seen at tap0/1/2 after 1/4/8 advancing edges; done one cycle after it leaves stage 8.
